rstl_conv_reader: RTL and testbench

//   Read side of the convolution result memory (memory_rstl_conv). After a convolution pass has

---
 rtl/rstl_conv_reader_pkg.sv | 21 ++
 rtl/rstl_conv_reader_if.sv | 34 +++
 rtl/rstl_conv_reader_fifo.sv | 44 ++++
 rtl/rstl_conv_reader.sv | 102 ++++++++++
 tb/tb_rstl_conv_reader.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rstl_conv_reader_pkg.sv
// Shared FSM state type and default widths for the convolution result reader.
// Optional feature macro: RSTL_LAST_EN adds a one-bit end-of-frame marker to each FIFO entry.
package rstl_conv_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_NUM_RES = 16;

`ifdef RSTL_LAST_EN
    localparam int LAST_W = 1;
`else
    localparam int LAST_W = 0;
`endif

endpackage

// File: rtl/rstl_conv_reader_if.sv
// Result-memory read port plus valid/ready result stream seen by the reader.
// Optional feature macro: RSTL_LAST_EN adds out_last to the stream.
interface rstl_conv_reader_if
    import rstl_conv_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              ren;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
`ifdef RSTL_LAST_EN
    logic              out_last;
`endif

    modport master (
        output ren, raddr, out_data, out_valid,
`ifdef RSTL_LAST_EN
        output out_last,
`endif
        input  rdata, out_ready
    );

    modport slave (
        input  ren, raddr, out_data, out_valid,
`ifdef RSTL_LAST_EN
        input  out_last,
`endif
        output rdata, out_ready
    );
endinterface

// File: rtl/rstl_conv_reader_fifo.sv
// Two-entry first-word-fall-through register FIFO; dout always shows the head entry.
module rstl_conv_reader_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] tail;

    // Head/tail shift register; pop is only ever requested when count is non-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) dout <= din;
                    else               tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    dout  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        dout <= din;
                    end else begin
                        dout <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/rstl_conv_reader.sv
// Streams NUM_RES results from the convolution result memory in ascending address order.
// Optional feature macro: RSTL_LAST_EN drives bus.out_last on the final result of each frame.
module rstl_conv_reader
    import rstl_conv_reader_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_RES = DEF_NUM_RES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    rstl_conv_reader_if.master bus
);
    localparam int               CNT_W    = ADDR_W + 1;
    localparam int               FIFO_W   = DATA_W + LAST_W;
    localparam logic [CNT_W-1:0] NUM_CNT  = CNT_W'(NUM_RES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_RES - 1);

    state_t             state;
    logic [CNT_W-1:0]   issued;
    logic [CNT_W-1:0]   sent;
    logic               inflight;
    logic               pop;
    logic [1:0]         count;
    logic [2:0]         used;
    logic [FIFO_W-1:0]  din;
    logic [FIFO_W-1:0]  dout;

    // Slots already claimed: held words plus the word arriving now, less the one leaving now.
    assign used          = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign bus.out_valid = (count != 2'd0);
    assign pop           = bus.out_valid & bus.out_ready;
    assign bus.ren       = (state == RUN) && (issued < NUM_CNT) && (used < 3'd2);
    assign bus.raddr     = issued[ADDR_W-1:0];
    assign bus.out_data  = dout[DATA_W-1:0];

`ifdef RSTL_LAST_EN
    logic inflight_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inflight_last <= 1'b0;
        else      inflight_last <= bus.ren && (issued == LAST_IDX);
    end

    assign din          = {inflight_last, bus.rdata};
    assign bus.out_last = dout[DATA_W] & bus.out_valid;
`else
    assign din = bus.rdata;
`endif

    rstl_conv_reader_fifo #(.W(FIFO_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .count (count)
    );

    // Frame FSM; issued is cleared on the final transfer so raddr rests at 0 between frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            issued   <= '0;
            sent     <= '0;
            inflight <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            inflight <= bus.ren;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        issued <= '0;
                        sent   <= '0;
                    end
                end
                RUN: begin
                    if (bus.ren) issued <= issued + CNT_W'(1);
                    if (pop) begin
                        sent <= sent + CNT_W'(1);
                        if (sent == LAST_IDX) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            issued <= '0;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rstl_conv_reader.sv
// Directed bench for rstl_conv_reader: a 16-result instance and a single-result instance.
// Define RSTL_LAST_EN to also exercise out_last.
module tb_rstl_conv_reader;
    import rstl_conv_reader_pkg::*;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic start  = 1'b0;
    logic start1 = 1'b0;
    logic busy, done, busy1, done1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] mem [16];

    rstl_conv_reader_if #(.DATA_W(8), .ADDR_W(4)) bus  ();
    rstl_conv_reader_if #(.DATA_W(8), .ADDR_W(4)) bus1 ();

    always #5 clk = ~clk;

    rstl_conv_reader #(.DATA_W(8), .ADDR_W(4), .NUM_RES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus)
    );

    rstl_conv_reader #(.DATA_W(8), .ADDR_W(4), .NUM_RES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .bus(bus1)
    );

    // Synchronous-read result memory: data valid the cycle after ren
    always @(posedge clk) begin
        if (bus.ren)  bus.rdata  <= mem[bus.raddr];
        if (bus1.ren) bus1.rdata <= mem[bus1.raddr];
    end

    task automatic test_reset();
        bus.out_ready = 1'b0;
        bus1.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.ren !== 1'b0) begin errors++; $display("[TB] FAIL reset_ren: got %b expected 0", bus.ren); end
        checks++; if (bus.raddr !== 4'd0) begin errors++; $display("[TB] FAIL reset_raddr: got %0d expected 0", bus.raddr); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", bus.out_data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_stream();
        logic [7:0] exp_data;
        bus.out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            exp_data = 8'(c - 11);
            checks++; if (busy !== (c <= 18)) begin errors++; $display("[TB] FAIL stream_busy c=%0d: got %b", c, busy); end
            checks++; if (done !== (c == 19)) begin errors++; $display("[TB] FAIL stream_done c=%0d: got %b", c, done); end
            checks++; if (bus.out_valid !== (c >= 3 && c <= 18)) begin errors++; $display("[TB] FAIL stream_valid c=%0d: got %b", c, bus.out_valid); end
            checks++; if (bus.ren !== (c <= 16)) begin errors++; $display("[TB] FAIL stream_ren c=%0d: got %b", c, bus.ren); end
            if (c <= 16) begin
                checks++; if (bus.raddr !== 4'(c - 1)) begin errors++; $display("[TB] FAIL stream_raddr c=%0d: got %0d expected %0d", c, bus.raddr, c - 1); end
            end
            if (c >= 3 && c <= 18) begin
                checks++; if (bus.out_data !== exp_data) begin errors++; $display("[TB] FAIL stream_data c=%0d: got %h expected %h", c, bus.out_data, exp_data); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [39:0] pat = 40'h9A6D3B5ED7;
        logic [7:0]  last_data = 8'h00;
        logic        stalled = 1'b0;
        logic        seen_done = 1'b0;
        logic        pop;
        int          idx = 0;
        int          reads = 0;
        @(negedge clk); start = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 120 && !seen_done; c++) begin
            if (c > 0) @(negedge clk);
            bus.out_ready = (c < 40) ? pat[c] : 1'b1;
            #1;
            pop = bus.out_valid & bus.out_ready;
            if (stalled) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== last_data) begin errors++; $display("[TB] FAIL bp_hold c=%0d: got %b/%h expected 1/%h", c, bus.out_valid, bus.out_data, last_data); end
            end
            if (bus.ren) begin
                checks++; if (bus.raddr !== 4'(reads) || (reads - idx - int'(pop)) >= 2) begin errors++; $display("[TB] FAIL bp_issue c=%0d: raddr %0d expected %0d, held %0d", c, bus.raddr, reads, reads - idx); end
                reads++;
            end
            if (pop) begin
                checks++; if (bus.out_data !== 8'(idx - 8)) begin errors++; $display("[TB] FAIL bp_data idx=%0d: got %h expected %h", idx, bus.out_data, 8'(idx - 8)); end
                idx++;
            end
            stalled = bus.out_valid & ~bus.out_ready;
            last_data = bus.out_data;
            if (done) seen_done = 1'b1;
        end
        checks++; if (!seen_done || idx != 16 || reads != 16) begin errors++; $display("[TB] FAIL bp_end: done %b transfers %0d reads %0d expected 1 16 16", seen_done, idx, reads); end
    endtask

    task automatic test_stall_start();
        int   reads = 0;
        int   idx = 0;
        logic seen_done = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (bus.ren) begin
                checks++; if (bus.raddr !== 4'(reads)) begin errors++; $display("[TB] FAIL stall_raddr c=%0d: got %0d expected %0d", c, bus.raddr, reads); end
                reads++;
            end
            if (c >= 3) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hF8) begin errors++; $display("[TB] FAIL stall_head c=%0d: got %b/%h expected 1/f8", c, bus.out_valid, bus.out_data); end
            end
        end
        checks++; if (reads != 2) begin errors++; $display("[TB] FAIL stall_reads: got %0d expected 2", reads); end
        for (int c = 0; c < 40 && !seen_done; c++) begin
            @(negedge clk); bus.out_ready = 1'b1;
            #1;
            if (bus.ren) reads++;
            if (bus.out_valid) begin
                checks++; if (bus.out_data !== 8'(idx - 8)) begin errors++; $display("[TB] FAIL stall_data idx=%0d: got %h expected %h", idx, bus.out_data, 8'(idx - 8)); end
                idx++;
            end
            if (done) seen_done = 1'b1;
        end
        checks++; if (!seen_done || idx != 16 || reads != 16) begin errors++; $display("[TB] FAIL stall_end: done %b transfers %0d reads %0d expected 1 16 16", seen_done, idx, reads); end
    endtask

    task automatic test_start_ignored();
        int   idx = 0;
        int   reads = 0;
        logic seen_done = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) begin
                checks++; if (bus.out_data !== 8'(idx - 8)) begin errors++; $display("[TB] FAIL busy_start_data idx=%0d: got %h expected %h", idx, bus.out_data, 8'(idx - 8)); end
                idx++;
            end
        end
        checks++; if (done !== 1'b1 || idx != 16) begin errors++; $display("[TB] FAIL busy_start_frame: done %b transfers %0d expected 1 16", done, idx); end
        @(negedge clk); start = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || bus.ren !== 1'b0) begin errors++; $display("[TB] FAIL done_start_busy: got busy %b ren %b expected 0 0", busy, bus.ren); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL done_start_idle: got %b expected 0", busy); end
        idx = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 25 && !seen_done; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (bus.ren) begin
                checks++; if (bus.raddr !== 4'(reads)) begin errors++; $display("[TB] FAIL replay_raddr: got %0d expected %0d", bus.raddr, reads); end
                reads++;
            end
            if (bus.out_valid) begin
                checks++; if (bus.out_data !== 8'(idx - 8)) begin errors++; $display("[TB] FAIL replay_data idx=%0d: got %h expected %h", idx, bus.out_data, 8'(idx - 8)); end
                idx++;
            end
            if (done) seen_done = 1'b1;
        end
        checks++; if (!seen_done || idx != 16 || reads != 16) begin errors++; $display("[TB] FAIL replay_end: done %b transfers %0d reads %0d expected 1 16 16", seen_done, idx, reads); end
    endtask

    task automatic test_mid_reset();
        logic seen_done = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 2; c <= 9; c++) @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hFE) begin errors++; $display("[TB] FAIL midrst_7th: got %b/%h expected 1/fe", bus.out_valid, bus.out_data); end
        #1 rst = 1'b0;
        #1;
        checks++; if (bus.ren !== 1'b0 || bus.raddr !== 4'd0 || bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ctrl: got ren %b raddr %0d valid %b expected 0 0 0", bus.ren, bus.raddr, bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out: got data %h busy %b done %b expected 00 0 0", bus.out_data, busy, done); end
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_quiet c=%0d: got done %b busy %b expected 0 0", c, done, busy); end
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        checks++; if (bus.ren !== 1'b1 || bus.raddr !== 4'd0) begin errors++; $display("[TB] FAIL midrst_restart: got ren %b raddr %0d expected 1 0", bus.ren, bus.raddr); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hF8) begin errors++; $display("[TB] FAIL midrst_first: got %b/%h expected 1/f8", bus.out_valid, bus.out_data); end
        for (int c = 0; c < 30 && !seen_done; c++) begin
            @(negedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        checks++; if (!seen_done) begin errors++; $display("[TB] FAIL midrst_drain: got done 0 expected 1"); end
    endtask

    task automatic test_single();
        bus1.out_ready = 1'b1;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        #1;
        checks++; if (bus1.ren !== 1'b1 || bus1.raddr !== 4'd0 || busy1 !== 1'b1) begin errors++; $display("[TB] FAIL single_c1: got ren %b raddr %0d busy %b expected 1 0 1", bus1.ren, bus1.raddr, busy1); end
        @(negedge clk); #1;
        checks++; if (bus1.ren !== 1'b0 || bus1.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_c2: got ren %b valid %b expected 0 0", bus1.ren, bus1.out_valid); end
        @(negedge clk); #1;
        checks++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== 8'hF8 || busy1 !== 1'b1) begin errors++; $display("[TB] FAIL single_c3: got %b/%h busy %b expected 1/f8 1", bus1.out_valid, bus1.out_data, busy1); end
        @(negedge clk); #1;
        checks++; if (done1 !== 1'b1 || busy1 !== 1'b0 || bus1.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_c4: got done %b busy %b valid %b expected 1 0 0", done1, busy1, bus1.out_valid); end
        @(negedge clk); #1;
        checks++; if (done1 !== 1'b0) begin errors++; $display("[TB] FAIL single_c5: got done %b expected 0", done1); end
    endtask

`ifdef RSTL_LAST_EN
    task automatic test_last();
        int   idx = 0;
        int   stalls = 0;
        logic seen_done = 1'b0;
        @(negedge clk); start = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 40 && !seen_done; c++) begin
            if (c > 1) @(negedge clk);
            if (idx == 15 && bus.out_valid && stalls < 3) begin
                bus.out_ready = 1'b0;
                stalls++;
            end else begin
                bus.out_ready = 1'b1;
            end
            #1;
            if (bus.out_valid) begin
                checks++; if (bus.out_last !== (idx == 15) || (idx == 15 && bus.out_data !== 8'h07)) begin errors++; $display("[TB] FAIL last_flag idx=%0d: got last %b data %h", idx, bus.out_last, bus.out_data); end
                if (bus.out_ready) idx++;
            end
            if (done) seen_done = 1'b1;
        end
        checks++; if (!seen_done || idx != 16 || stalls != 3) begin errors++; $display("[TB] FAIL last_end: done %b transfers %0d stalls %0d expected 1 16 3", seen_done, idx, stalls); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i - 8);
        test_reset();
        test_stream();
        test_backpressure();
        test_stall_start();
        test_start_ignored();
        test_mid_reset();
        test_single();
`ifdef RSTL_LAST_EN
        test_last();
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
